// File: rtl/systolic_result_drain.sv
// Snapshots the packed PE result bus on a compute_done rising edge and streams it row-major over
// valid/ready. Define DRAIN_RELU_EN to clamp negative words to zero on the output path.
module systolic_result_drain #(
  parameter int unsigned NUM_ROW       = 8,
  parameter int unsigned NUM_COL       = 8,
  parameter int unsigned OUT_WORD_SIZE = 24,
  localparam int unsigned ROW_W        = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1,
  localparam int unsigned COL_W        = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      compute_done,
  input  logic [0:OUT_WORD_SIZE*NUM_ROW*NUM_COL-1] pe_register_vals,
  output logic [OUT_WORD_SIZE-1:0]                  out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [ROW_W-1:0]                          out_row,
  output logic [COL_W-1:0]                          out_col,
  output logic                                      out_last,
  output logic                                      busy,
  output logic                                      drain_done,
  output logic                                      overrun
);

  localparam int unsigned NUM_PE = NUM_ROW * NUM_COL;
  localparam int unsigned SNAP_W = NUM_PE * OUT_WORD_SIZE;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [0:SNAP_W-1]  snapshot_q;
  logic               done_q;
  logic               armed_q;
  logic               overrun_q, overrun_d;

  logic               start;
  logic               capture;
  logic               streaming;
  logic               at_last;
  int unsigned        sel_idx;
  logic [OUT_WORD_SIZE-1:0] sel_word;
  logic [OUT_WORD_SIZE-1:0] word_out;

  // armed_q stays low while compute_done has been high since reset, so a level that is
  // already high when reset releases must fall and rise again before it counts as a start.
  assign start     = compute_done && !done_q && armed_q;
  assign capture   = start && (state_q == StIdle);
  assign streaming = (state_q == StStream);
  assign at_last   = (row_q == ROW_W'(NUM_ROW - 1)) && (col_q == COL_W'(NUM_COL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      snapshot_q <= '0;
      done_q     <= 1'b0;
      armed_q    <= !compute_done;
      overrun_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      done_q    <= compute_done;
      armed_q   <= armed_q || !compute_done;
      overrun_q <= overrun_d;
      if (capture) begin
        snapshot_q <= pe_register_vals;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    overrun_d = overrun_q || (start && (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStream;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StStream: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = StDone;
          end else if (col_q == COL_W'(NUM_COL - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Row-major word select; PE(r,c) sits at word index r*NUM_COL+c with its MSB at the low bit.
  always_comb begin
    sel_idx  = 32'(row_q) * NUM_COL + 32'(col_q);
    sel_word = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (sel_idx == i) begin
        sel_word = snapshot_q[i*OUT_WORD_SIZE +: OUT_WORD_SIZE];
      end
    end
  end

`ifdef DRAIN_RELU_EN
  assign word_out = sel_word[OUT_WORD_SIZE-1] ? '0 : sel_word;
`else
  assign word_out = sel_word;
`endif

  assign out_valid  = streaming;
  assign out_data   = streaming ? word_out : '0;
  assign out_row    = streaming ? row_q : '0;
  assign out_col    = streaming ? col_q : '0;
  assign out_last   = streaming && at_last;
  assign busy       = (state_q != StIdle);
  assign drain_done = (state_q == StDone);
  assign overrun    = overrun_q;

endmodule
